// File: rtl/cdb_arbiter_if.sv
// Result/broadcast bus between the functional units and the CDB arbiter.
interface cdb_arbiter_if #(
  parameter int unsigned N_SRC  = 5,
  parameter int unsigned CDB_W  = 3,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic                      flush;
  logic                      cdb_hold;
  logic [N_SRC-1:0]          src_valid;
  logic [N_SRC*TAG_W-1:0]    src_tag;
  logic [N_SRC*DATA_W-1:0]   src_data;
  logic                      fu_stall;
  logic [CDB_W-1:0]          cdb_valid;
  logic [CDB_W*TAG_W-1:0]    cdb_tag;
  logic [CDB_W*DATA_W-1:0]   cdb_data;
  logic [CDB_W*SRC_W-1:0]    cdb_src;
  logic                      overflow_err;

  // Producer side: FUs plus pipeline control.
  modport master (
    output flush, cdb_hold, src_valid, src_tag, src_data,
    input  fu_stall, cdb_valid, cdb_tag, cdb_data, cdb_src, overflow_err
  );

  // Consumer side: the arbiter.
  modport slave (
    input  flush, cdb_hold, src_valid, src_tag, src_data,
    output fu_stall, cdb_valid, cdb_tag, cdb_data, cdb_src, overflow_err
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs, round-robin grant of up
// to CDB_W heads per cycle onto a registered broadcast bus, global FU stall.
// Optional macro CDB_BYPASS_EN: an empty source with a valid input may win
// arbitration directly from its input (one-edge latency).
module cdb_arbiter #(
  parameter int unsigned N_SRC  = 5,
  parameter int unsigned CDB_W  = 3,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);
  localparam int unsigned SRC_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned SUM_W  = SRC_W + 1;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned SLOT_W = $clog2(CDB_W + 1);

`ifdef CDB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } res_t;

  res_t             mem_q   [N_SRC][DEPTH];
  logic [PTR_W-1:0] rd_q    [N_SRC];
  logic [PTR_W-1:0] rd_d    [N_SRC];
  logic [PTR_W-1:0] wr_q    [N_SRC];
  logic [PTR_W-1:0] wr_d    [N_SRC];
  logic [CNT_W-1:0] cnt_q   [N_SRC];
  logic [CNT_W-1:0] cnt_d   [N_SRC];
  logic [SRC_W-1:0] rr_q, rr_d;
  logic             stall_q, stall_d;
  logic             ovf_q, ovf_d;
  logic [CDB_W-1:0] vld_q, vld_d;
  res_t             slot_q  [CDB_W];
  res_t             slot_d  [CDB_W];
  logic [SRC_W-1:0] ssrc_q  [CDB_W];
  logic [SRC_W-1:0] ssrc_d  [CDB_W];

  res_t             in_res  [N_SRC];
  res_t             head    [N_SRC];
  logic [N_SRC-1:0] empty, cand, grant, pop, byp, push, full, wen;

  logic [CDB_W*TAG_W-1:0]  cdb_tag_c;
  logic [CDB_W*DATA_W-1:0] cdb_data_c;
  logic [CDB_W*SRC_W-1:0]  cdb_src_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Unpack inputs and select each source's arbitration head.
  always_comb begin
    empty = '0;
    cand  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      in_res[i].tag  = bus.src_tag[i*TAG_W +: TAG_W];
      in_res[i].data = bus.src_data[i*DATA_W +: DATA_W];
      empty[i]       = (cnt_q[i] == '0);
      cand[i]        = !empty[i] || (BYPASS && bus.src_valid[i]);
      head[i]        = empty[i] ? in_res[i] : mem_q[i][rd_q[i]];
    end
  end

  // Round-robin scan from rr_q, packing grants into slots in scan order.
  always_comb begin
    logic [SUM_W-1:0]  sum;
    logic [SRC_W-1:0]  idx;
    logic [SLOT_W-1:0] n_gr;
    grant = '0;
    vld_d = '0;
    rr_d  = rr_q;
    n_gr  = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < CDB_W; k++) begin
      slot_d[k] = '0;
      ssrc_d[k] = '0;
    end
    if (!bus.cdb_hold && !bus.flush) begin
      for (int j = 0; j < N_SRC; j++) begin
        sum = SUM_W'(rr_q) + SUM_W'(j);
        idx = (sum >= SUM_W'(N_SRC)) ? SRC_W'(sum - SUM_W'(N_SRC)) : SRC_W'(sum);
        if (cand[idx] && (n_gr < SLOT_W'(CDB_W))) begin
          grant[idx]   = 1'b1;
          vld_d[n_gr]  = 1'b1;
          slot_d[n_gr] = head[idx];
          ssrc_d[n_gr] = idx;
          n_gr         = n_gr + SLOT_W'(1);
          rr_d         = (idx == SRC_W'(N_SRC - 1)) ? '0 : idx + SRC_W'(1);
        end
      end
    end
  end

  // FIFO pointer/count next state, overflow detection and stall computation.
  always_comb begin
    pop     = '0;
    byp     = '0;
    push    = '0;
    full    = '0;
    wen     = '0;
    ovf_d   = ovf_q;
    stall_d = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      pop[i]  = grant[i] && !empty[i];
      byp[i]  = grant[i] && empty[i];
      push[i] = bus.src_valid[i] && !byp[i];
      full[i] = (cnt_q[i] == CNT_W'(DEPTH));
      wen[i]  = push[i] && (!full[i] || pop[i]) && !bus.flush;
      if (push[i] && full[i] && !pop[i] && !bus.flush) begin
        ovf_d = 1'b1;
      end
      if (bus.flush) begin
        rd_d[i]  = '0;
        wr_d[i]  = '0;
        cnt_d[i] = '0;
      end else begin
        rd_d[i]  = pop[i] ? ptr_inc(rd_q[i]) : rd_q[i];
        wr_d[i]  = wen[i] ? ptr_inc(wr_q[i]) : wr_q[i];
        cnt_d[i] = cnt_q[i] + CNT_W'(wen[i]) - CNT_W'(pop[i]);
      end
      if (cnt_d[i] >= CNT_W'(DEPTH - 1)) begin
        stall_d = 1'b1;
      end
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (wen[i]) begin
        mem_q[i][wr_q[i]] <= in_res[i];
      end
    end
  end

  // Control and broadcast registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SRC; i++) begin
        rd_q[i]  <= '0;
        wr_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      for (int k = 0; k < CDB_W; k++) begin
        slot_q[k] <= '0;
        ssrc_q[k] <= '0;
      end
      rr_q    <= '0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        rd_q[i]  <= rd_d[i];
        wr_q[i]  <= wr_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      for (int k = 0; k < CDB_W; k++) begin
        slot_q[k] <= slot_d[k];
        ssrc_q[k] <= ssrc_d[k];
      end
      rr_q    <= rr_d;
      stall_q <= stall_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

  // Flatten broadcast slots onto the bus.
  always_comb begin
    cdb_tag_c  = '0;
    cdb_data_c = '0;
    cdb_src_c  = '0;
    for (int k = 0; k < CDB_W; k++) begin
      cdb_tag_c[k*TAG_W +: TAG_W]    = slot_q[k].tag;
      cdb_data_c[k*DATA_W +: DATA_W] = slot_q[k].data;
      cdb_src_c[k*SRC_W +: SRC_W]    = ssrc_q[k];
    end
  end

  assign bus.fu_stall     = stall_q;
  assign bus.overflow_err = ovf_q;
  assign bus.cdb_valid    = vld_q;
  assign bus.cdb_tag      = cdb_tag_c;
  assign bus.cdb_data     = cdb_data_c;
  assign bus.cdb_src      = cdb_src_c;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of the arbitration rules.
module tb_cdb_arbiter;
  localparam int unsigned N_SRC  = 5;
  localparam int unsigned CDB_W  = 3;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SRC_W  = $clog2(N_SRC);

`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_SRC(N_SRC), .CDB_W(CDB_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(.N_SRC(N_SRC), .CDB_W(CDB_W), .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  // Reference model state.
  ent_t                    q [N_SRC][$];
  int                      rr;
  logic [CDB_W-1:0]        m_vld;
  logic [CDB_W*TAG_W-1:0]  m_tag;
  logic [CDB_W*DATA_W-1:0] m_data;
  logic [CDB_W*SRC_W-1:0]  m_src;
  logic                    m_stall;
  logic                    m_ovf;

  int vectors     = 0;
  int miscompares = 0;

  function automatic ent_t mk(input int i);
    ent_t e;
    e.tag  = bus.src_tag[i*TAG_W +: TAG_W];
    e.data = bus.src_data[i*DATA_W +: DATA_W];
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_SRC; i++) q[i].delete();
    rr = 0; m_vld = '0; m_tag = '0; m_data = '0; m_src = '0;
    m_stall = 1'b0; m_ovf = 1'b0;
  endtask

  // Effect of one clock edge on the model, using the inputs currently driven.
  task automatic model_edge();
    bit   bp [N_SRC];
    ent_t e;
    int   k, last;
    if (rst) begin model_reset(); return; end
    m_vld = '0; m_tag = '0; m_data = '0; m_src = '0;
    for (int i = 0; i < N_SRC; i++) bp[i] = 1'b0;
    if (bus.flush) begin
      for (int i = 0; i < N_SRC; i++) q[i].delete();
      m_stall = 1'b0;
      return;
    end
    k = 0; last = -1;
    if (!bus.cdb_hold) begin
      for (int j = 0; j < N_SRC; j++) begin
        int s;
        s = (rr + j) % N_SRC;
        if (k < CDB_W) begin
          if (q[s].size() > 0) e = q[s].pop_front();
          else if (BYP && bus.src_valid[s]) begin e = mk(s); bp[s] = 1'b1; end
          else continue;
          m_vld[k] = 1'b1;
          m_tag[k*TAG_W +: TAG_W]    = e.tag;
          m_data[k*DATA_W +: DATA_W] = e.data;
          m_src[k*SRC_W +: SRC_W]    = SRC_W'(s);
          k++;
          last = s;
        end
      end
    end
    if (last >= 0) rr = (last + 1) % N_SRC;
    for (int i = 0; i < N_SRC; i++) begin
      if (bus.src_valid[i] && !bp[i]) begin
        if (q[i].size() < DEPTH) q[i].push_back(mk(i));
        else m_ovf = 1'b1;
      end
    end
    m_stall = 1'b0;
    for (int i = 0; i < N_SRC; i++) if (q[i].size() >= DEPTH - 1) m_stall = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("cdb_valid", 128'(bus.cdb_valid), 128'(m_vld));
    chk("cdb_tag", 128'(bus.cdb_tag), 128'(m_tag));
    chk("cdb_data", 128'(bus.cdb_data), 128'(m_data));
    chk("cdb_src", 128'(bus.cdb_src), 128'(m_src));
    chk("fu_stall", 128'(bus.fu_stall), 128'(m_stall));
    chk("overflow_err", 128'(bus.overflow_err), 128'(m_ovf));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    bus.src_valid = '0; bus.cdb_hold = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N_SRC; i++) begin
      bus.src_tag[i*TAG_W +: TAG_W]    = TAG_W'($urandom);
      bus.src_data[i*DATA_W +: DATA_W] = $urandom;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset with all sources valid: outputs stay zero.
    rst = 1'b1;
    idle();
    rand_payload();
    bus.src_valid = '1;
    model_reset();
    #2;
    check_all();
    repeat (3) step();
    rst = 1'b0;
    idle();
    repeat (2) step();
    chk("post_reset_quiet", 128'(bus.cdb_valid), 128'(3'b000));

    // Single result on source 2.
    bus.src_valid = 5'b00100;
    bus.src_tag[2*TAG_W +: TAG_W]    = 6'h05;
    bus.src_data[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
    step();
    idle();
    if (!BYP) begin
      chk("single_early", 128'(bus.cdb_valid), 128'(3'b000));
      step();
    end
    chk("single_valid", 128'(bus.cdb_valid), 128'(3'b001));
    chk("single_tag", 128'(bus.cdb_tag[TAG_W-1:0]), 128'(6'h05));
    chk("single_data", 128'(bus.cdb_data[DATA_W-1:0]), 128'(32'hDEADBEEF));
    chk("single_src", 128'(bus.cdb_src[SRC_W-1:0]), 128'(3'd2));
    step();
    chk("single_once", 128'(bus.cdb_valid), 128'(3'b000));

    // Oversubscription from rr_ptr=0.
    pulse_reset();
    rand_payload();
    bus.src_valid = '1;
    step();
    idle();
    repeat (4) step();

    // Hold with an FU that sees stall one cycle late, then a forced third push.
    bus.cdb_hold = 1'b1;
    rand_payload();
    bus.src_valid = 5'b00001;
    step();
    chk("hold_stall_up", 128'(bus.fu_stall), 128'(1'b1));
    rand_payload();
    step();
    bus.src_valid = '0;
    repeat (2) step();
    chk("hold_no_ovf", 128'(bus.overflow_err), 128'(1'b0));
    rand_payload();
    bus.src_valid = 5'b00001;
    step();
    chk("hold_ovf", 128'(bus.overflow_err), 128'(1'b1));
    idle();
    repeat (3) step();

    // Flush with three buffered results and a same-edge push.
    pulse_reset();
    bus.cdb_hold = 1'b1;
    rand_payload();
    bus.src_valid = 5'b01110;
    step();
    bus.flush = 1'b1;
    rand_payload();
    bus.src_valid = 5'b10000;
    step();
    chk("flush_valid", 128'(bus.cdb_valid), 128'(3'b000));
    chk("flush_stall", 128'(bus.fu_stall), 128'(1'b0));
    idle();
    repeat (3) step();
    rand_payload();
    bus.src_valid = 5'b00001;
    step();
    idle();
    repeat (3) step();

    // Fairness: sources 0 and 4 continuously valid.
    for (int c = 0; c < 8; c++) begin
      rand_payload();
      bus.src_valid = 5'b10001;
      step();
    end
    idle();
    repeat (3) step();

    // Random traffic; FUs mostly obey stall; occasional flush and async reset.
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else begin
        rand_payload();
        bus.cdb_hold  = ($urandom_range(0, 3) == 0);
        bus.flush     = ($urandom_range(0, 31) == 0);
        bus.src_valid = N_SRC'($urandom);
        if (m_stall && ($urandom_range(0, 63) != 0)) bus.src_valid = '0;
        step();
      end
    end
    idle();
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
